// File: rtl/lpce_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | lpce_pkg : shared constants and helpers for the LPCE TX arbiter |
// | rev 1.0                                                         |
// +-----------------------------------------------------------------+
package lpce_pkg;

  localparam int FRAME_W       = 128;
  localparam int DEF_N_REQ     = 4;
  localparam int DEF_BURST_MAX = 4;

  localparam logic [0:0] c_IDLE = 1'b0;
  localparam logic [0:0] c_SEND = 1'b1;

  typedef logic [2:0] port_id_t;

  // Search distance of port idx from the slot just after ptr (0 = first looked at).
  function automatic int rr_dist(input int idx, input int ptr, input int n);
    return (idx + 2 * n - 1 - ptr) % n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lpce_rr_pick.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | lpce_rr_pick : rotate-priority picker, first candidate after ptr|
// | rev 1.0                                                         |
// +-----------------------------------------------------------------+
module lpce_rr_pick
  import lpce_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ
) (
  input  logic [N_REQ-1:0] i_cand,
  input  port_id_t         i_ptr,
  output logic             o_found,
  output port_id_t         o_idx
);

  int w_best;
  int w_dist;

  always_comb begin
    w_best = N_REQ;
    w_dist = 0;
    o_idx  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_dist = rr_dist(i, int'(i_ptr), N_REQ);
      if (i_cand[i] && (w_dist < w_best)) begin
        w_best = w_dist;
        o_idx  = port_id_t'(i);
      end
    end
    o_found = (w_best < N_REQ);
  end

endmodule
`default_nettype wire

// File: rtl/lpce_tx_arb.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | lpce_tx_arb : round-robin burst arbiter into the LPCE TX FIFO   |
// | rev 1.0                                                         |
// +-----------------------------------------------------------------+
module lpce_tx_arb
  import lpce_pkg::*;
#(
  parameter int N_REQ     = DEF_N_REQ,
  parameter int BURST_MAX = DEF_BURST_MAX
) (
  input  logic                     WR_CLK,
  input  logic                     WR_RSTn,
  input  logic [N_REQ-1:0]         REQ_VALID,
  input  logic [N_REQ*FRAME_W-1:0] REQ_DATA,
  output logic [N_REQ-1:0]         REQ_READY,
  input  logic [N_REQ-1:0]         PORT_EN,
  output logic                     WR_EN,
  output logic [FRAME_W-1:0]       WR_DATA,
  input  logic                     WR_FULL,
  output logic [2:0]               GRANT_ID,
  output logic                     BUSY
);

  logic [0:0]         r_state;
  port_id_t           r_grant;
  port_id_t           r_ptr;
  logic [3:0]         r_burst;
  logic               r_wr_en;
  logic [FRAME_W-1:0] r_wr_data;

  logic [N_REQ-1:0]   w_cand;
  logic [N_REQ-1:0]   w_gsel;
  logic [FRAME_W-1:0] w_gdata;
  logic               w_found;
  port_id_t           w_idx;
  logic               w_send;
  logic               w_en_g;
  logic               w_valid_g;
  logic               w_rdy;
  logic               w_xfer;
  logic               w_last;

  assign w_cand = REQ_VALID & PORT_EN;

  lpce_rr_pick #(
    .N_REQ (N_REQ)
  ) u_pick (
    .i_cand  (w_cand),
    .i_ptr   (r_ptr),
    .o_found (w_found),
    .o_idx   (w_idx)
  );

  always_comb begin
    w_gsel  = '0;
    w_gdata = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_gsel[i] = (port_id_t'(i) == r_grant);
      w_gdata   = w_gdata | (REQ_DATA[i*FRAME_W +: FRAME_W] & {FRAME_W{w_gsel[i]}});
    end
  end

  assign w_send    = (r_state == c_SEND);
  assign w_en_g    = |(PORT_EN & w_gsel);
  assign w_valid_g = |(REQ_VALID & w_gsel);
  // The !r_wr_en term spaces writes two cycles apart so a late-registered FULL is safe.
  assign w_rdy     = w_send & ~WR_FULL & ~r_wr_en & w_en_g;
  assign REQ_READY = w_gsel & {N_REQ{w_rdy}};
  assign w_xfer    = w_rdy & w_valid_g;
  assign w_last    = (r_burst == 4'(BURST_MAX - 1));

  always_ff @(posedge WR_CLK) begin
    if (!WR_RSTn) begin
      r_state   <= c_IDLE;
      r_grant   <= '0;
      r_ptr     <= port_id_t'(N_REQ - 1);
      r_burst   <= '0;
      r_wr_en   <= 1'b0;
      r_wr_data <= '0;
    end else begin
      r_wr_en <= w_xfer;
      if (w_xfer) begin
        r_wr_data <= w_gdata;
      end
      case (r_state)
        c_IDLE: begin
          if (w_found) begin
            r_grant <= w_idx;
            r_burst <= '0;
            r_state <= c_SEND;
          end
        end
        c_SEND: begin
          if (w_xfer) begin
            r_burst <= r_burst + 4'd1;
            if (w_last) begin
              r_state <= c_IDLE;
              r_ptr   <= r_grant;
            end
          end else if (!w_valid_g || !w_en_g) begin
            r_state <= c_IDLE;
            r_ptr   <= r_grant;
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  assign WR_EN    = r_wr_en;
  assign WR_DATA  = r_wr_data;
  assign BUSY     = w_send;
  assign GRANT_ID = w_send ? r_grant : 3'd0;

endmodule
`default_nettype wire

// File: tb/tb_lpce_tx_arb.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | tb_lpce_tx_arb : randomized bench with behavioural arbiter model|
// | rev 1.0                                                         |
// +-----------------------------------------------------------------+
module tb_lpce_tx_arb;

  localparam int N  = 4;
  localparam int BM = 4;
  localparam int W  = 128;

  logic           WR_CLK = 1'b0;
  logic           WR_RSTn;
  logic [N-1:0]   REQ_VALID;
  logic [N*W-1:0] REQ_DATA;
  logic [N-1:0]   REQ_READY;
  logic [N-1:0]   PORT_EN;
  logic           WR_EN;
  logic [W-1:0]   WR_DATA;
  logic           WR_FULL;
  logic [2:0]     GRANT_ID;
  logic           BUSY;

  always #5 WR_CLK = ~WR_CLK;

  lpce_tx_arb #(
    .N_REQ     (N),
    .BURST_MAX (BM)
  ) dut (
    .WR_CLK    (WR_CLK),
    .WR_RSTn   (WR_RSTn),
    .REQ_VALID (REQ_VALID),
    .REQ_DATA  (REQ_DATA),
    .REQ_READY (REQ_READY),
    .PORT_EN   (PORT_EN),
    .WR_EN     (WR_EN),
    .WR_DATA   (WR_DATA),
    .WR_FULL   (WR_FULL),
    .GRANT_ID  (GRANT_ID),
    .BUSY      (BUSY)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: arbiter described as "who holds the grant, how many frames sent".
  bit         m_known = 0;
  bit         m_busy;
  int         m_g, m_cnt, m_ptr;
  bit         m_wen;
  logic [W-1:0] m_wdata;
  bit         m_zero;
  int         n_dut_wr = 0;
  int         n_exp_wr = 0;
  bit         cap_en = 0;
  bit         prev_busy = 0;
  int         gq[$];

  function automatic logic [W-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [N*W-1:0] rnd_frames();
    logic [N*W-1:0] d;
    for (int i = 0; i < N; i++) d[i*W +: W] = rnd128();
    return d;
  endfunction

  task automatic cycle(input bit rstn, input logic [N-1:0] v, input logic [N-1:0] en,
                       input bit full, input logic [N*W-1:0] d);
    logic [N-1:0] exp_rdy;
    bit xfer;
    int p;
    WR_RSTn = rstn; REQ_VALID = v; PORT_EN = en; WR_FULL = full; REQ_DATA = d;
    #1;
    if (m_known) begin
      exp_rdy = '0;
      if (m_busy && en[m_g] && !full && !m_wen) exp_rdy[m_g] = 1'b1;
      chk("ready", REQ_READY, exp_rdy);
      chk("grant", GRANT_ID, m_busy ? m_g : 0);
      chk("busy",  BUSY, m_busy);
      chk("wr_en", WR_EN, m_wen);
      if (m_wen) chk("wr_data", WR_DATA, m_wdata);
      else if (m_zero) chk("wr_data_rst", WR_DATA, '0);
      if (WR_EN) n_dut_wr++;
      if (m_wen) n_exp_wr++;
    end
    if (cap_en && BUSY && !prev_busy) gq.push_back(int'(GRANT_ID));
    prev_busy = BUSY;

    xfer = m_busy && v[m_g] && en[m_g] && !full && !m_wen;
    if (!rstn) begin
      m_known = 1; m_busy = 0; m_ptr = N - 1; m_cnt = 0; m_g = 0;
      m_wen = 0; m_wdata = '0; m_zero = 1;
    end else if (m_known) begin
      m_wen = xfer;
      if (xfer) begin
        m_wdata = d[m_g*W +: W];
        m_zero  = 0;
      end
      if (!m_busy) begin
        for (int k = 1; k <= N; k++) begin
          p = (m_ptr + k) % N;
          if (v[p] && en[p]) begin
            m_busy = 1; m_g = p; m_cnt = 0;
            break;
          end
        end
      end else if (xfer) begin
        m_cnt++;
        if (m_cnt == BM) begin m_busy = 0; m_ptr = m_g; end
      end else if (!(v[m_g] && en[m_g])) begin
        m_busy = 0; m_ptr = m_g;
      end
    end
    @(posedge WR_CLK);
    #1;
  endtask

  logic [N*W-1:0] a5;
  int exp_order[5];

  initial begin
    WR_RSTn = 0; REQ_VALID = '0; PORT_EN = '0; WR_FULL = 0; REQ_DATA = '0;
    @(posedge WR_CLK);
    #1;

    // Single requester with a constant pattern: READY on the 2nd cycle, alternate writes.
    for (int i = 0; i < N; i++) a5[i*W +: W] = {16{8'hA5}};
    cycle(0, '0, '0, 0, '0);
    cycle(0, '0, '0, 0, '0);
    for (int c = 0; c < 14; c++) cycle(1, 4'b0001, 4'b1111, 0, a5);

    // All ports valid: round-robin order and burst length.
    cycle(0, '0, 4'b1111, 0, '0);
    cap_en = 1; gq.delete(); prev_busy = 0;
    for (int c = 0; c < 44; c++) cycle(1, 4'b1111, 4'b1111, 0, rnd_frames());
    cap_en = 0;
    exp_order = '{0, 1, 2, 3, 0};
    chk("grant_cnt", gq.size() >= 5, 1'b1);
    for (int i = 0; i < 5 && i < gq.size(); i++) chk("grant_order", gq[i], exp_order[i]);

    // FULL asserted for a 10-cycle stretch mid-burst, then random FULL bursts.
    for (int c = 0; c < 3; c++) cycle(1, 4'b1111, 4'b1111, 0, rnd_frames());
    for (int c = 0; c < 10; c++) cycle(1, 4'b1111, 4'b1111, 1, rnd_frames());
    for (int c = 0; c < 60; c++)
      cycle(1, 4'b1111, 4'b1111, ($urandom_range(0, 3) == 0), rnd_frames());

    // Only ports 1 and 3 enabled.
    for (int c = 0; c < 40; c++) cycle(1, 4'b1111, 4'b1010, 0, rnd_frames());

    // Port 2 drops VALID part way through its burst.
    cycle(0, '0, 4'b1111, 0, '0);
    cycle(1, 4'b0100, 4'b1111, 0, rnd_frames());
    for (int c = 0; c < 4; c++) cycle(1, 4'b0100, 4'b1111, 0, rnd_frames());
    for (int c = 0; c < 6; c++) cycle(1, 4'b1000, 4'b1111, 0, rnd_frames());

    // Fully random traffic with occasional resets, including mid-transfer.
    for (int c = 0; c < 500; c++)
      cycle(($urandom_range(0, 29) != 0), 4'($urandom), 4'($urandom | 32'h1 << $urandom_range(0, 3)),
            ($urandom_range(0, 4) == 0), rnd_frames());

    // Reset landing on a transfer cycle.
    for (int c = 0; c < 2; c++) cycle(1, 4'b0010, 4'b1111, 0, rnd_frames());
    cycle(0, 4'b0010, 4'b1111, 0, rnd_frames());
    for (int c = 0; c < 4; c++) cycle(1, 4'b1111, 4'b1111, 0, rnd_frames());

    for (int c = 0; c < 4; c++) cycle(1, '0, 4'b1111, 0, '0);
    chk("write_count", n_dut_wr, n_exp_wr);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
